mult: RTL and testbench



---
 rtl/mult_pkg.sv | 23 ++
 rtl/booth_step.sv | 41 ++++
 rtl/mult.sv | 86 ++++++++
 tb/tb_mult.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mult_pkg
//  Purpose  : Shared constants for the sequential Booth multiplier:
//             FSM state encoding, Booth recode patterns, default width.
//  Revision : 1.0 - initial release
// ============================================================================
package mult_pkg;

  // Default operand width of the multiplier datapath
  localparam int DEFAULT_WIDTH = 32;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Radix-2 Booth recode of the two LSBs of the product register
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
//  Module   : booth_step
//  Purpose  : One combinational radix-2 Booth iteration. Adds or subtracts
//             the sign-extended multiplicand into the WIDTH+1 bit upper
//             accumulator, then arithmetic-shifts the whole register right.
//  Revision : 1.0 - initial release
// ============================================================================
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [2*WIDTH+1:0] i_p,
  input  logic [WIDTH-1:0]   i_m,
  output logic [2*WIDTH+1:0] o_p_next
);

  // One guard bit keeps -M representable when M is the most negative value
  logic [WIDTH:0] w_m_ext;
  logic [WIDTH:0] w_upper;
  logic [WIDTH:0] w_acc;

  assign w_m_ext = {i_m[WIDTH-1], i_m};
  assign w_upper = i_p[2*WIDTH+1:WIDTH+1];

  // Booth recode: 01 adds M, 10 subtracts M, 00/11 leave the accumulator alone
  always_comb begin
    w_acc = w_upper;
    case (i_p[1:0])
      BOOTH_ADD: w_acc = w_upper + w_m_ext;
      BOOTH_SUB: w_acc = w_upper - w_m_ext;
      default:   w_acc = w_upper;
    endcase
  end

  // Arithmetic shift right by one: replicate the accumulator sign bit
  assign o_p_next = {w_acc[WIDTH], w_acc, i_p[WIDTH:1]};

endmodule : booth_step
`default_nettype wire

// File: rtl/mult.sv
`default_nettype none
// ============================================================================
//  Module   : mult
//  Purpose  : Sequential signed WIDTH x WIDTH multiplier (MIPS MULT) using
//             radix-2 Booth recoding, one iteration per clock. Writes the
//             HI/LO pair and raises mult_stop when the product is ready.
//  Revision : 1.0 - initial release
// ============================================================================
module mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mult_control,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mult_stop
);

  localparam logic [CNT_W-1:0] c_last_iter = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

  logic [1:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_m;
  // Layout: {accumulator[WIDTH:0], multiplier[WIDTH-1:0], booth_guard}
  logic [2*WIDTH+1:0] r_p;
  logic [2*WIDTH+1:0] w_p_next;

  booth_step #(
    .WIDTH (WIDTH)
  ) u_booth_step (
    .i_p      (r_p),
    .i_m      (r_m),
    .o_p_next (w_p_next)
  );

  // FSM, iteration counter, product register and result outputs;
  // a start in any state (including RUN) reloads and restarts
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_m       <= '0;
      r_p       <= '0;
      hi        <= '0;
      lo        <= '0;
      mult_stop <= 1'b0;
    end else if (mult_control) begin
      r_state   <= ST_RUN;
      r_cnt     <= '0;
      r_m       <= A;
      r_p       <= {{(WIDTH+1){1'b0}}, B, 1'b0};
      hi        <= '0;
      lo        <= '0;
      mult_stop <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_p   <= w_p_next;
          r_cnt <= r_cnt + c_cnt_one;
          // Last iteration: the shifted register already holds the product
          if (r_cnt == c_last_iter) begin
            r_state   <= ST_DONE;
            hi        <= w_p_next[2*WIDTH:WIDTH+1];
            lo        <= w_p_next[WIDTH:1];
            mult_stop <= 1'b1;
          end
        end
        ST_IDLE, ST_DONE: begin
          r_state <= r_state;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule : mult
`default_nettype wire

// File: tb/tb_mult.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult
//  Purpose  : Self-checking bench for mult. Stimulus pushes the expected
//             product and start edge into a scoreboard; a monitor pops and
//             compares whenever mult_stop rises, and checks hold/idle values.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult;

  logic        clk;
  logic        reset;
  logic        mult_control;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        mult_stop;

  typedef struct {
    logic [63:0] prod;
    int          start_cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic        prev_stop = 1'b0;
  logic [31:0] held_hi = '0;
  logic [31:0] held_lo = '0;

  mult #(
    .WIDTH (32),
    .CNT_W (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .mult_control (mult_control),
    .A            (A),
    .B            (B),
    .hi           (hi),
    .lo           (lo),
    .mult_stop    (mult_stop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain signed 64-bit multiplication
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b);
    longint pa;
    longint pb;
    pa = longint'($signed(a));
    pb = longint'($signed(b));
    return 64'(pa * pb);
  endfunction

  // Monitor: compare on each rising mult_stop, check hold in DONE, zeros otherwise
  always @(negedge clk) begin
    if (mult_stop && !prev_stop) begin
      if (sb.size() == 0) begin
        chk("unexpected_stop", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_hi", {32'd0, hi}, {32'd0, e.prod[63:32]});
        chk("result_lo", {32'd0, lo}, {32'd0, e.prod[31:0]});
        chk("latency", 64'(cyc - e.start_cyc), 64'd32);
        held_hi = e.prod[63:32];
        held_lo = e.prod[31:0];
      end
    end else if (mult_stop) begin
      chk("hold_hi", {32'd0, hi}, {32'd0, held_hi});
      chk("hold_lo", {32'd0, lo}, {32'd0, held_lo});
    end else begin
      chk("busy_zero", {hi, lo}, 64'd0);
    end
    prev_stop = mult_stop;
  end

  task automatic do_start(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    A            = a;
    B            = b;
    mult_control = 1'b1;
    e.prod       = model(a, b);
    e.start_cyc  = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    mult_control = 1'b0;
    A            = $urandom;
    B            = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout", 64'(sb.size()), 64'd0);
      sb = {};
    end
    @(negedge clk);
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b);
    do_start(a, b);
    wait_idle();
  endtask

  initial begin
    reset        = 1'b0;
    mult_control = 1'b0;
    A            = '0;
    B            = '0;
    #1;
    chk("reset_hi", {32'd0, hi}, 64'd0);
    chk("reset_lo", {32'd0, lo}, 64'd0);
    chk("reset_stop", {63'd0, mult_stop}, 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // Directed operand patterns
    mul(32'd3, 32'd5);
    mul(-32'sd7, 32'd6);
    mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    mul(32'd0, 32'h1234_5678);
    mul(32'h8000_0000, 32'h8000_0000);
    mul(32'h7FFF_FFFF, 32'h7FFF_FFFF);
    mul(32'h8000_0000, 32'h7FFF_FFFF);
    mul(32'h1234_5678, 32'h8000_0000);

    // Restart during RUN: the aborted product must never appear
    do_start(32'd3, 32'd5);
    repeat (7) @(negedge clk);
    sb = {};
    do_start(32'd2, 32'd4);
    wait_idle();
    chk("restart_lo", {32'd0, lo}, 64'd8);

    // Hold in DONE for 50 cycles with inputs toggling
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      A = $urandom;
      B = $urandom;
    end
    chk("hold_stop", {63'd0, mult_stop}, 64'd1);

    // Asynchronous reset from DONE clears outputs between edges
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("rst_done_out", {hi, lo}, 64'd0);
    chk("rst_done_stop", {63'd0, mult_stop}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    // Asynchronous reset mid-RUN discards the partial result
    do_start(32'd9, 32'd9);
    repeat (5) @(negedge clk);
    #3 reset = 1'b0;
    sb = {};
    #1;
    chk("rst_run_out", {hi, lo}, 64'd0);
    chk("rst_run_stop", {63'd0, mult_stop}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    mul(32'd4, -32'sd2);
    chk("post_rst_hi", {32'd0, hi}, 64'hFFFF_FFFF);
    chk("post_rst_lo", {32'd0, lo}, 64'hFFFF_FFF8);

    // Randomized operands
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = $urandom;
      case (i % 8)
        0: ra = 32'h8000_0000;
        1: rb = 32'h8000_0000;
        2: ra = 32'($urandom_range(0, 15)) - 32'd8;
        default: ;
      endcase
      mul(ra, rb);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_mult
`default_nettype wire
